seq_logic_unit: RTL and testbench
=================================

SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-006 The block SHALL have port op, input, 2 bits: 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-007 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands.
REQ-008 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port out, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have port zero, output, 1 bit: registered flag, high when out == 0.
REQ-012 The block SHALL have port parity, output, 1 bit, present only when LOGIC_PARITY_EN is defined: XOR-reduction of out.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL capture a, b and op into internal registers, clear the chunk counter to 0 and enter BUSY.
REQ-015 In BUSY, each edge SHALL compute op over captured chunk i (bits [i*CHUNK +: CHUNK], LSB chunk first) into an internal shadow result and then increment i.
REQ-016 When chunk N-1 is processed, the block SHALL copy the full shadow result to out, update zero (and parity) from that result, and enter DONE on the same edge.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-018 Latency: done SHALL be high during the Nth cycle after the accepting edge (N=4 by default; N=1 when CHUNK=WIDTH).
REQ-019 out, zero and parity SHALL change only on entry to DONE and SHALL hold their values otherwise, including through the whole of the next BUSY period.
REQ-020 start SHALL be ignored in BUSY and DONE; a, b and op changing during BUSY SHALL NOT affect the result.
REQ-021 start held high continuously SHALL launch back-to-back operations, one accepted in each IDLE cycle.
REQ-022 The chunk counter SHALL be ceil(log2(N)) bits wide (minimum 1) and SHALL never exceed N-1.

Reset
REQ-023 When rst=1 at an edge, the block SHALL go to IDLE with out=0, zero=1, done=0, parity=0, the counter at 0 and the captured registers at 0, so that ready=1 in the following cycle.
REQ-024 rst SHALL take priority over start and SHALL abort a BUSY operation in any cycle; no done pulse SHALL follow.

Configuration
REQ-025 With LOGIC_PARITY_EN defined, the parity port and its register SHALL exist and update per REQ-016.
REQ-026 Without LOGIC_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-027 XOR test: WIDTH=16, CHUNK=4, op=10, a=0xAAAA, b=0x5555, start for 1 cycle -> ready low 4 cycles, done high in the 4th cycle, out=0xFFFF, zero=0, parity=0.
REQ-028 XOR test: op=10, a=0xFFFF, b=0xFFFF -> out=0x0000, zero=1, parity=0; XOR test: a=0x0000, b=0xFFBF -> out=0xFFBF, zero=0, parity=1.
REQ-029 Input-change test: start AND with a=0xF0F0, b=0xFF00, then change a, b, op and pulse start during BUSY -> out=0xF000, single done, no second operation.
REQ-030 Mid-operation reset: rst in 2nd BUSY cycle -> next cycle IDLE, out=0, zero=1, ready=1, no done.
REQ-031 Parameter test: WIDTH=8, CHUNK=8, op=11, a=0x3C, b=0x0F, start held high -> out=0xCC, done every 2nd cycle (1-cycle latency), ready toggles.
REQ-032 Build test: compile with and without LOGIC_PARITY_EN -> identical out, zero and done traces for REQ-027 to REQ-029.

Source files
------------

// File: rtl/seq_logic_unit.sv
// Chunk-serial bitwise logic unit (AND/OR/XOR/XNOR) with IDLE/BUSY/DONE FSM.
// Define LOGIC_PARITY_EN to add the registered parity output.
module seq_logic_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero
`ifdef LOGIC_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
`ifdef LOGIC_PARITY_EN
    logic             r_parity;
`endif

    logic             w_busy;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [CW-1:0]    w_idx;
    logic [31:0]      w_shamt;
    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_src_b;
    logic [1:0]       w_src_op;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK-1:0] w_chunk;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_shadow_nxt;

    // Chunk 0 is computed on the accepting edge straight from the inputs;
    // r_cnt then holds the index of the last chunk processed.
    assign w_busy   = (r_state == S_BUSY);
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_step   = w_accept || w_busy;
    assign w_idx    = w_busy ? r_cnt + CW'(1) : '0;
    assign w_last   = (w_idx == CW'(N - 1));
    assign w_src_a  = w_busy ? r_a : a;
    assign w_src_b  = w_busy ? r_b : b;
    assign w_src_op = w_busy ? r_op : op;
    assign w_shamt  = 32'(w_idx) * 32'(CHUNK);
    assign w_ca     = CHUNK'(w_src_a >> w_shamt);
    assign w_cb     = CHUNK'(w_src_b >> w_shamt);
    assign w_mask   = WIDTH'({CHUNK{1'b1}});

    always_comb begin
        w_chunk = '0;
        case (w_src_op)
            2'b00:   w_chunk = w_ca & w_cb;
            2'b01:   w_chunk = w_ca | w_cb;
            2'b10:   w_chunk = w_ca ^ w_cb;
            default: w_chunk = ~(w_ca ^ w_cb);
        endcase
    end

    assign w_shadow_nxt = (r_shadow & ~(w_mask << w_shamt))
                        | (WIDTH'(w_chunk) << w_shamt);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_last ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_out    <= '0;
            r_zero   <= 1'b1;
`ifdef LOGIC_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= op;
            end
            if (w_step) begin
                r_shadow <= w_shadow_nxt;
                r_cnt    <= w_idx;
                if (w_last) begin
                    r_out    <= w_shadow_nxt;
                    r_zero   <= ~|w_shadow_nxt;
`ifdef LOGIC_PARITY_EN
                    r_parity <= ^w_shadow_nxt;
`endif
                end
            end
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign done   = (r_state == S_DONE);
    assign out    = r_out;
    assign zero   = r_zero;
`ifdef LOGIC_PARITY_EN
    assign parity = r_parity;
`endif

endmodule

// File: tb/tb_seq_logic_unit.sv
// Self-checking bench for seq_logic_unit: directed and randomized operations
// against a whole-word reference model, plus an 8/8 single-chunk instance.
module tb_seq_logic_unit;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] out;
    logic        zero;
    logic        parity;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        ready8;
    logic        done8;
    logic [7:0]  out8;
    logic        zero8;
    logic        parity8;

    int checks;
    int errors;
    logic [15:0] m_out;

    seq_logic_unit #(.WIDTH(16), .CHUNK(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .out    (out),
        .zero   (zero)
`ifdef LOGIC_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    seq_logic_unit #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .op     (op8),
        .a      (a8),
        .b      (b8),
        .ready  (ready8),
        .done   (done8),
        .out    (out8),
        .zero   (zero8)
`ifdef LOGIC_PARITY_EN
        ,
        .parity (parity8)
`endif
    );

`ifndef LOGIC_PARITY_EN
    assign parity  = 1'b0;
    assign parity8 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_op(input logic [1:0] o,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input logic [15:0] exp);
        chk({tag, "_out"}, 32'(out), 32'(exp));
        chk({tag, "_zero"}, 32'(zero), 32'(exp == 16'h0));
`ifdef LOGIC_PARITY_EN
        chk({tag, "_parity"}, 32'(parity), 32'(^exp));
`endif
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [15:0] x, input logic [15:0] y,
                          input bit scramble);
        logic [15:0] exp;
        exp = ref_op(o, x, y);
        chk({tag, "_ready_pre"}, 32'(ready), 32'd1);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        for (int k = 1; k <= N; k++) begin
            chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
            chk({tag, "_done"}, 32'(done), 32'(k == N));
            if (k < N) begin
                chk_result({tag, "_hold"}, m_out);
                if (scramble) begin
                    a     = 16'($urandom);
                    b     = 16'($urandom);
                    op    = 2'($urandom);
                    start = 1'($urandom_range(0, 1));
                end
            end else begin
                chk_result(tag, exp);
                start = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk({tag, "_ready_post"}, 32'(ready), 32'd1);
        chk({tag, "_done_post"}, 32'(done), 32'd0);
        chk_result({tag, "_post"}, exp);
        m_out = exp;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_out  = 16'h0;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = 16'h0;
        b      = 16'h0;
        start8 = 1'b0;
        op8    = 2'b00;
        a8     = 8'h0;
        b8     = 8'h0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk_result("rst", 16'h0);
        chk("rst_ready8", 32'(ready8), 32'd1);
        chk("rst_out8", 32'(out8), 32'h0);
        chk("rst_zero8", 32'(zero8), 32'd1);

        run_op("xor_aa55", 2'b10, 16'hAAAA, 16'h5555, 1'b0);
        run_op("xor_ffff", 2'b10, 16'hFFFF, 16'hFFFF, 1'b0);
        run_op("xor_ffbf", 2'b10, 16'h0000, 16'hFFBF, 1'b0);
        run_op("and_chg", 2'b00, 16'hF0F0, 16'hFF00, 1'b1);
        chk("and_chg_val", 32'(m_out), 32'h0000_F000);
        step();
        chk("no_second_op", 32'(ready), 32'd1);
        run_op("or_dir", 2'b01, 16'h1200, 16'h0034, 1'b0);
        run_op("xnor_dir", 2'b11, 16'h1234, 16'h1234, 1'b0);

        for (int t = 0; t < 24; t++) begin
            run_op("rand", 2'($urandom), 16'($urandom),
                   16'($urandom), 1'b1);
        end

        start = 1'b1;
        op    = 2'b01;
        a     = 16'h1234;
        b     = 16'h8001;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_out = 16'h0;
        chk("mrst_ready", 32'(ready), 32'd1);
        chk("mrst_done", 32'(done), 32'd0);
        chk_result("mrst", 16'h0);
        for (int k = 0; k < N + 1; k++) begin
            step();
            chk("mrst_nodone", 32'(done), 32'd0);
            chk("mrst_idle", 32'(ready), 32'd1);
        end
        run_op("after_rst", 2'b10, 16'h0F0F, 16'h00FF, 1'b1);

        start8 = 1'b1;
        op8    = 2'b11;
        a8     = 8'h3C;
        b8     = 8'h0F;
        for (int j = 1; j <= 8; j++) begin
            step();
            chk("p8_done", 32'(done8), 32'(j % 2));
            chk("p8_ready", 32'(ready8), 32'((j + 1) % 2));
            chk("p8_out", 32'(out8), 32'h0000_00CC);
            chk("p8_zero", 32'(zero8), 32'd0);
`ifdef LOGIC_PARITY_EN
            chk("p8_parity", 32'(parity8), 32'd0);
`endif
        end
        start8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
